// File: rtl/ram_dp_sync_clr.sv
// Dual-port synchronous RAM that zero-fills itself after reset, one word per cycle,
// then serves two independent read/write ports with a configurable read pipeline.
module ram_dp_sync_clr #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address_0,
    input  logic                  cs_0,
    input  logic                  we_0,
    input  logic                  oe_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic                  rvalid_0,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic                  cs_1,
    input  logic                  we_1,
    input  logic                  oe_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_1,
    output logic                  init_busy,
    output logic                  collision
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic act_0, wr_0, rd_0, in_rng_0;
    logic act_1, wr_1, rd_1, in_rng_1;
    logic [DATA_WIDTH-1:0] rd_word_0, rd_word_1;

    logic [READ_LATENCY-1:0] vpipe_0, vpipe_1;
    logic [DATA_WIDTH-1:0]   dpipe_0 [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dpipe_1 [READ_LATENCY];

    assign act_0    = cs_0 & ~init_busy;
    assign wr_0     = act_0 & we_0;
    assign rd_0     = act_0 & ~we_0 & oe_0;
    assign in_rng_0 = {1'b0, address_0} < DEPTH_EXT;

    assign act_1    = cs_1 & ~init_busy;
    assign wr_1     = act_1 & we_1;
    assign rd_1     = act_1 & ~we_1 & oe_1;
    assign in_rng_1 = {1'b0, address_1} < DEPTH_EXT;

    // Clear sweep FSM; init_busy is registered alongside the state and mirrors it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                READY: begin
                    state     <= READY;
                    init_busy <= 1'b0;
                end
                default: begin
                    state     <= CLEAR;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Port 0 is written last so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (wr_1 && in_rng_1) mem[address_1] <= wdata_1;
                if (wr_0 && in_rng_0) mem[address_0] <= wdata_0;
            end
        end
    end

    // Cross-port bypass selects the word being written this cycle when WRITE_FIRST is set.
    always_comb begin
        rd_word_0 = '0;
        if (in_rng_0) begin
            rd_word_0 = mem[address_0];
            if ((WRITE_FIRST != 0) && wr_1 && (address_1 == address_0))
                rd_word_0 = wdata_1;
        end
    end

    always_comb begin
        rd_word_1 = '0;
        if (in_rng_1) begin
            rd_word_1 = mem[address_1];
            if ((WRITE_FIRST != 0) && wr_0 && (address_0 == address_1))
                rd_word_1 = wdata_0;
        end
    end

    // Data stages carry zero whenever their valid bit is clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_0 <= '0;
            vpipe_1 <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dpipe_0[i] <= '0;
                dpipe_1[i] <= '0;
            end
        end else begin
            vpipe_0[0] <= rd_0;
            vpipe_1[0] <= rd_1;
            dpipe_0[0] <= rd_0 ? rd_word_0 : '0;
            dpipe_1[0] <= rd_1 ? rd_word_1 : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vpipe_0[i] <= vpipe_0[i-1];
                vpipe_1[i] <= vpipe_1[i-1];
                dpipe_0[i] <= dpipe_0[i-1];
                dpipe_1[i] <= dpipe_1[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) collision <= 1'b0;
        else     collision <= wr_0 & wr_1 & (address_0 == address_1);
    end

    assign rvalid_0 = vpipe_0[READ_LATENCY-1];
    assign rvalid_1 = vpipe_1[READ_LATENCY-1];
    assign rdata_0  = dpipe_0[READ_LATENCY-1];
    assign rdata_1  = dpipe_1[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_dp_sync_clr.sv
// Bench for ram_dp_sync_clr: a default instance (256 words, latency 1, read-old) and a
// 200-word, latency-2, write-first instance driven by the same stimulus.
module tb_ram_dp_sync_clr;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] address_0, address_1, wdata_0, wdata_1;
    logic       cs_0, we_0, oe_0, cs_1, we_1, oe_1;

    logic [7:0] rdata_0_a, rdata_1_a, rdata_0_b, rdata_1_b;
    logic       rvalid_0_a, rvalid_1_a, busy_a, col_a;
    logic       rvalid_0_b, rvalid_1_b, busy_b, col_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_dp_sync_clr u_a (
        .clk(clk), .rst(rst),
        .address_0(address_0), .cs_0(cs_0), .we_0(we_0), .oe_0(oe_0), .wdata_0(wdata_0),
        .rdata_0(rdata_0_a), .rvalid_0(rvalid_0_a),
        .address_1(address_1), .cs_1(cs_1), .we_1(we_1), .oe_1(oe_1), .wdata_1(wdata_1),
        .rdata_1(rdata_1_a), .rvalid_1(rvalid_1_a),
        .init_busy(busy_a), .collision(col_a)
    );

    ram_dp_sync_clr #(.RAM_DEPTH(200), .READ_LATENCY(2), .WRITE_FIRST(1)) u_b (
        .clk(clk), .rst(rst),
        .address_0(address_0), .cs_0(cs_0), .we_0(we_0), .oe_0(oe_0), .wdata_0(wdata_0),
        .rdata_0(rdata_0_b), .rvalid_0(rvalid_0_b),
        .address_1(address_1), .cs_1(cs_1), .we_1(we_1), .oe_1(oe_1), .wdata_1(wdata_1),
        .rdata_1(rdata_1_b), .rvalid_1(rvalid_1_b),
        .init_busy(busy_b), .collision(col_b)
    );

    typedef struct {
        logic       cs0, we0, oe0;
        logic [7:0] a0, wd0;
        logic       cs1, we1, oe1;
        logic [7:0] a1, wd1;
        logic       a_rv0; logic [7:0] a_rd0; logic a_rv1; logic [7:0] a_rd1; logic a_col;
        logic       b_rv0; logic [7:0] b_rd0; logic b_rv1; logic [7:0] b_rd1; logic b_col;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c0, w0, o0, input logic [7:0] a0, d0,
                         input logic c1, w1, o1, input logic [7:0] a1, d1);
        cs_0 = c0; we_0 = w0; oe_0 = o0; address_0 = a0; wdata_0 = d0;
        cs_1 = c1; we_1 = w1; oe_1 = o1; address_1 = a1; wdata_1 = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    // Samples at each falling edge until both instances leave the sweep; ports are
    // poked with reads and colliding writes that must all be ignored while busy.
    task automatic run_sweep(input string tag);
        int ca = 0;
        int cb = 0;
        int guard = 0;
        while ((busy_a || busy_b) && guard < 600) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            chk({tag, "_quiet_a"}, {rvalid_0_a, rvalid_1_a, col_a}, 0);
            chk({tag, "_quiet_b"}, {rvalid_0_b, rvalid_1_b, col_b}, 0);
            if (guard < 150 && guard[0])
                drive(1, 1, 0, 8'h05, 8'h77, 1, 1, 0, 8'h05, 8'h88);
            else if (guard < 150)
                drive(1, 0, 1, 8'h10, 8'h00, 1, 0, 1, 8'h20, 8'h00);
            else
                idle();
            guard++;
            @(negedge clk);
        end
        idle();
        chk({tag, "_done"}, {busy_a, busy_b}, 0);
        chk({tag, "_cycles_a"}, ca, 256);
        chk({tag, "_cycles_b"}, cb, 200);
    endtask

    initial begin
        vecs[0]  = '{1,1,1,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 0,8'h00,0,8'h00,0, 0,8'h00,0,8'h00,0};
        vecs[1]  = '{0,0,0,8'h00,8'h00, 1,0,1,8'h10,8'h00, 0,8'h00,1,8'hA5,0, 0,8'h00,0,8'h00,0};
        vecs[2]  = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00,0,8'h00,0, 0,8'h00,1,8'hA5,0};
        vecs[3]  = '{1,1,0,8'h20,8'h11, 1,1,0,8'h20,8'h22, 0,8'h00,0,8'h00,1, 0,8'h00,0,8'h00,1};
        vecs[4]  = '{1,0,1,8'h20,8'h00, 0,0,0,8'h00,8'h00, 1,8'h11,0,8'h00,0, 0,8'h00,0,8'h00,0};
        vecs[5]  = '{1,1,0,8'h30,8'h33, 1,1,0,8'h31,8'h55, 0,8'h00,0,8'h00,0, 1,8'h11,0,8'h00,0};
        vecs[6]  = '{1,1,0,8'h30,8'h44, 1,0,1,8'h30,8'h00, 0,8'h00,1,8'h33,0, 0,8'h00,0,8'h00,0};
        vecs[7]  = '{1,0,1,8'h30,8'h00, 1,0,1,8'h31,8'h00, 1,8'h44,1,8'h55,0, 0,8'h00,1,8'h44,0};
        vecs[8]  = '{1,0,1,8'h10,8'h00, 1,0,1,8'h20,8'h00, 1,8'hA5,1,8'h11,0, 1,8'h44,1,8'h55,0};
        vecs[9]  = '{0,1,1,8'h10,8'hEE, 0,1,1,8'h10,8'hDD, 0,8'h00,0,8'h00,0, 1,8'hA5,1,8'h11,0};
        vecs[10] = '{1,0,1,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,8'hA5,0,8'h00,0, 0,8'h00,0,8'h00,0};
        vecs[11] = '{0,0,0,8'h00,8'h00, 1,1,0,8'hFA,8'hFF, 0,8'h00,0,8'h00,0, 1,8'hA5,0,8'h00,0};
        vecs[12] = '{0,0,0,8'h00,8'h00, 1,0,1,8'hFA,8'h00, 0,8'h00,1,8'hFF,0, 0,8'h00,0,8'h00,0};
        vecs[13] = '{1,0,1,8'hC7,8'h00, 0,0,0,8'h00,8'h00, 1,8'h00,0,8'h00,0, 0,8'h00,1,8'h00,0};
        vecs[14] = '{0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00,0,8'h00,0, 1,8'h00,0,8'h00,0};
        vecs[15] = '{1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 0,8'h00,0,8'h00,0, 0,8'h00,0,8'h00,0};

        // Reset state
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_out_a", {rvalid_0_a, rdata_0_a, rvalid_1_a, rdata_1_a, col_a}, 0);
        chk("rst_out_b", {rvalid_0_b, rdata_0_b, rvalid_1_b, rdata_1_b, col_b}, 0);
        chk("rst_busy", {busy_a, busy_b}, 2'b11);

        rst = 1'b0;
        run_sweep("sweep1");

        // Every word reads back zero; B answers 200..255 with zero and a valid pulse
        for (int i = 0; i < 258; i++) begin
            if (i < 256) drive(1, 0, 1, 8'(i), 8'h00, 1, 0, 1, 8'(255 - i), 8'h00);
            else         idle();
            @(negedge clk);
            if (i < 256)
                chk($sformatf("clr_a_%0d", i),
                    {rvalid_0_a, rdata_0_a, rvalid_1_a, rdata_1_a}, {1'b1, 8'h00, 1'b1, 8'h00});
            if (i >= 1 && i < 257)
                chk($sformatf("clr_b_%0d", i - 1),
                    {rvalid_0_b, rdata_0_b, rvalid_1_b, rdata_1_b}, {1'b1, 8'h00, 1'b1, 8'h00});
        end

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].cs0, vecs[i].we0, vecs[i].oe0, vecs[i].a0, vecs[i].wd0,
                  vecs[i].cs1, vecs[i].we1, vecs[i].oe1, vecs[i].a1, vecs[i].wd1);
            @(negedge clk);
            chk($sformatf("v%0d_a_p0", i), {rvalid_0_a, rdata_0_a}, {vecs[i].a_rv0, vecs[i].a_rd0});
            chk($sformatf("v%0d_a_p1", i), {rvalid_1_a, rdata_1_a}, {vecs[i].a_rv1, vecs[i].a_rd1});
            chk($sformatf("v%0d_a_col", i), col_a, vecs[i].a_col);
            chk($sformatf("v%0d_b_p0", i), {rvalid_0_b, rdata_0_b}, {vecs[i].b_rv0, vecs[i].b_rd0});
            chk($sformatf("v%0d_b_p1", i), {rvalid_1_b, rdata_1_b}, {vecs[i].b_rv1, vecs[i].b_rd1});
            chk($sformatf("v%0d_b_col", i), col_b, vecs[i].b_col);
        end
        idle();
        @(negedge clk);

        // Reset with reads in flight: B's two-stage reads must never surface
        drive(1, 0, 1, 8'h10, 8'h00, 1, 0, 1, 8'h20, 8'h00);
        @(negedge clk);
        chk("flight_a", {rvalid_0_a, rdata_0_a, rvalid_1_a, rdata_1_a}, {1'b1, 8'hA5, 1'b1, 8'h11});
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_a", {rvalid_0_a, rdata_0_a, rvalid_1_a, rdata_1_a, col_a}, 0);
        chk("midrst_b", {rvalid_0_b, rdata_0_b, rvalid_1_b, rdata_1_b, col_b}, 0);
        chk("midrst_busy", {busy_a, busy_b}, 2'b11);
        rst = 1'b0;
        run_sweep("sweep2");

        // The restarted sweep must have cleared previously written words
        drive(1, 0, 1, 8'h10, 8'h00, 1, 0, 1, 8'h20, 8'h00);
        @(negedge clk);
        idle();
        chk("reclr_a", {rvalid_0_a, rdata_0_a, rvalid_1_a, rdata_1_a}, {1'b1, 8'h00, 1'b1, 8'h00});
        @(negedge clk);
        chk("reclr_b", {rvalid_0_b, rdata_0_b, rvalid_1_b, rdata_1_b}, {1'b1, 8'h00, 1'b1, 8'h00});
        @(negedge clk);
        chk("tail_quiet", {rvalid_0_a, rvalid_1_a, rvalid_0_b, rvalid_1_b, rdata_0_b, rdata_1_b}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
